crop_plus_fifo: RTL and testbench
=================================

// Module: crop_plus_fifo
// PURPOSE
//  Streaming crop stage: accepts a raster-order IN_ROWS x IN_COLS pixel frame and forwards only the
//  OUT_ROWS x OUT_COLS window whose top-left corner is (crop_Y1, crop_X1).
//  Kept pixels are buffered in an internal FIFO so the downstream consumer can stall independently.
//  Sits between the image source and the filter stage (e.g. Gaussian).
//  All ports are AXI-Stream style valid/ready.
// PARAMETERS
//  PIXEL_BIT_WIDTH   16   pixel data width
//  IN_ROWS           100  input frame rows
//  IN_COLS           160  input frame columns
//  OUT_ROWS          48   crop window rows
//  OUT_COLS          48   crop window columns
//  IMG_ROW_BITWIDTH  10   width of row counters and of crop_Y1_TDATA
//  IMG_COL_BITWIDTH  10   width of column counters and of crop_X1_TDATA
//  FIFO_DEPTH        64   output FIFO entries (power of 2, >=2)
// PORTS
//  clk               in   1                 single clock, all logic on rising edge
//  reset             in   1                 synchronous, active-low reset (0 = reset)
//  pixel_in_TDATA    in   PIXEL_BIT_WIDTH   input pixel, raster order
//  pixel_in_TVALID   in   1                 input pixel valid
//  pixel_in_TREADY   out  1                 block accepts input pixel
//  crop_Y1_TDATA     in   IMG_ROW_BITWIDTH  window top row
//  crop_Y1_TVALID    in   1                 Y1 valid
//  crop_Y1_TREADY    out  1                 block accepts Y1
//  crop_X1_TDATA     in   IMG_COL_BITWIDTH  window left column (width set by IMG_ROW_BITWIDTH for compatibility; equal by default)
//  crop_X1_TVALID    in   1                 X1 valid
//  crop_X1_TREADY    out  1                 block accepts X1
//  pixel_out_TDATA   out  PIXEL_BIT_WIDTH   cropped pixel
//  pixel_out_TVALID  out  1                 cropped pixel valid
//  pixel_out_TREADY  in   1                 consumer ready
// BEHAVIOUR
//  Reset (reset=0 at a clk edge):
//   - pixel_in_TREADY=0, pixel_out_TVALID=0, crop_Y1/X1_TREADY=1.
//   - FIFO emptied, row/col counters=0, Y1/X1 "held" flags cleared.
//   - Reset mid-frame discards the partial frame and all buffered pixels.
//  Crop parameters:
//   - Y1 and X1 are each captured on their own handshake (TVALID & TREADY) into a holding register.
//   - crop_*_TREADY = !held; after capture it stays 0 until the frame ends.
//   - Y1 is clamped to IN_ROWS-OUT_ROWS and X1 to IN_COLS-OUT_COLS; max legal values pass unchanged
//     (100x160 -> 48x48: Y1 up to 52, X1 up to 112).
//  Input acceptance:
//   - pixel_in_TREADY = Y1_held & X1_held & (!in_window | !fifo_full), with in_window computed from
//     the current (row,col) counters.
//   - No pass-through when full, even if a read occurs in the same cycle.
//   - Each accepted pixel advances col; at col=IN_COLS-1 col wraps to 0 and row increments.
//   - On accepting pixel (IN_ROWS-1, IN_COLS-1): counters -> 0 and both held flags clear, so new
//     params are accepted next cycle.
//   - in_window = Y1<=row<Y1+OUT_ROWS and X1<=col<X1+OUT_COLS.
//   - In-window pixels are written to the FIFO; out-of-window pixels are consumed and dropped.
//  Output FIFO:
//   - Synchronous FIFO; pixel_out_TVALID = !empty; pixel_out_TDATA = head entry (first-word fall-through).
//   - Latency: a pixel written at edge N is visible on pixel_out_* after edge N.
//   - Pop on pixel_out_TVALID & pixel_out_TREADY.
//   - Simultaneous push and pop when not full and not empty: occupancy unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
//   - TDATA/TVALID hold steady while TVALID=1 and TREADY=0.
//   - Order preserved: outputs are the window in raster order, exactly OUT_ROWS*OUT_COLS per frame.
// TESTING
//  1. Reset, Y1=0, X1=0, input = index ramp (pixel value = i), sink always ready -> output = i for
//     i=r*160+c, r,c<48; 2304 beats; values strictly increasing.
//  2. Y1=52, X1=112 (max window) -> first output 8432, last output 15999; then crop_*_TREADY=1 again.
//  3. Y1=37, X1=59, TVALID=1, TREADY=0 -> FIFO fills to 64 entries, pixel_in_TREADY drops at the next
//     in-window pixel; then TREADY=1 -> drains and completes with no loss or duplication.
//  4. Random TVALID and random TREADY over 10 back-to-back frames -> each frame's output matches the
//     golden crop bit-exactly.
//  5. Reset asserted mid-frame with FIFO non-empty -> TVALID=0 next cycle; next full frame outputs the
//     correct window from pixel 0.
//  6. Y1=99, X1=200 (out of range) -> clamped to (52,112); output identical to scenario 2.

Source files
------------

// File: rtl/crop_plus_fifo.sv
// crop_plus_fifo: streaming raster-order crop with a first-word
// fall-through output FIFO; valid/ready on every port.
module crop_plus_fifo #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter int FIFO_DEPTH       = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
  input  logic                        pixel_in_TVALID,
  output logic                        pixel_in_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
  input  logic                        crop_Y1_TVALID,
  output logic                        crop_Y1_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0] crop_X1_TDATA,
  input  logic                        crop_X1_TVALID,
  output logic                        crop_X1_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
  output logic                        pixel_out_TVALID,
  input  logic                        pixel_out_TREADY
);

  localparam int RB = IMG_ROW_BITWIDTH;
  localparam int CB = IMG_COL_BITWIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [RB-1:0] Y_MAX    = RB'(IN_ROWS - OUT_ROWS);
  localparam logic [RB-1:0] X_MAX    = RB'(IN_COLS - OUT_COLS);
  localparam logic [RB-1:0] ROW_LAST = RB'(IN_ROWS - 1);
  localparam logic [CB-1:0] COL_LAST = CB'(IN_COLS - 1);
  localparam logic [RB:0]   OUT_H    = (RB+1)'(OUT_ROWS);
  localparam logic [CB:0]   OUT_W    = (CB+1)'(OUT_COLS);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [RB-1:0] y1;
  logic [CB-1:0] x1;
  logic          y1_held;
  logic          x1_held;
  logic [RB-1:0] row;
  logic [CB-1:0] col;

  logic [PIXEL_BIT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [CW-1:0]              count;

  logic [RB-1:0] y1_clamp;
  logic [RB-1:0] x1_clamp;
  logic          row_in;
  logic          col_in;
  logic          in_window;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic          frame_end;

  assign y1_clamp = (crop_Y1_TDATA > Y_MAX) ? Y_MAX : crop_Y1_TDATA;
  assign x1_clamp = (crop_X1_TDATA > X_MAX) ? X_MAX : crop_X1_TDATA;

  assign row_in = (row >= y1) &&
                  ({1'b0, row} < ({1'b0, y1} + OUT_H));
  assign col_in = (col >= x1) &&
                  ({1'b0, col} < ({1'b0, x1} + OUT_W));
  assign in_window = row_in && col_in;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Out-of-window pixels never need FIFO space, so only stall on full
  // when the current pixel would actually be stored.
  assign pixel_in_TREADY = y1_held && x1_held && (!in_window || !full);
  assign crop_Y1_TREADY  = !y1_held;
  assign crop_X1_TREADY  = !x1_held;

  assign accept    = pixel_in_TVALID && pixel_in_TREADY;
  assign push      = accept && in_window;
  assign pop       = !empty && pixel_out_TREADY;
  assign frame_end = accept && (row == ROW_LAST) && (col == COL_LAST);

  assign pixel_out_TVALID = !empty;
  assign pixel_out_TDATA  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      y1      <= '0;
      x1      <= '0;
      y1_held <= 1'b0;
      x1_held <= 1'b0;
    end else if (frame_end) begin
      y1_held <= 1'b0;
      x1_held <= 1'b0;
    end else begin
      if (crop_Y1_TVALID && !y1_held) begin
        y1      <= y1_clamp;
        y1_held <= 1'b1;
      end
      if (crop_X1_TVALID && !x1_held) begin
        x1      <= CB'(x1_clamp);
        x1_held <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RB'(1);
      end else begin
        col <= col + CB'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pixel_in_TDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_crop_plus_fifo.sv
// Directed bench for crop_plus_fifo on a reduced 12x20 -> 5x6 frame
// with an 8-entry FIFO.
module tb_crop_plus_fifo;

  localparam int PW    = 16;
  localparam int IR    = 12;
  localparam int IC    = 20;
  localparam int OR    = 5;
  localparam int OC    = 6;
  localparam int RBW   = 10;
  localparam int DEPTH = 8;
  localparam int FRAME = IR * IC;
  localparam int OUT_N = OR * OC;

  logic          clk;
  logic          reset;
  logic [PW-1:0] pixel_in_TDATA;
  logic          pixel_in_TVALID;
  logic          pixel_in_TREADY;
  logic [RBW-1:0] crop_Y1_TDATA;
  logic          crop_Y1_TVALID;
  logic          crop_Y1_TREADY;
  logic [RBW-1:0] crop_X1_TDATA;
  logic          crop_X1_TVALID;
  logic          crop_X1_TREADY;
  logic [PW-1:0] pixel_out_TDATA;
  logic          pixel_out_TVALID;
  logic          pixel_out_TREADY;

  crop_plus_fifo #(
    .PIXEL_BIT_WIDTH (PW),
    .IN_ROWS         (IR),
    .IN_COLS         (IC),
    .OUT_ROWS        (OR),
    .OUT_COLS        (OC),
    .IMG_ROW_BITWIDTH(RBW),
    .IMG_COL_BITWIDTH(RBW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_in_TDATA  (pixel_in_TDATA),
    .pixel_in_TVALID (pixel_in_TVALID),
    .pixel_in_TREADY (pixel_in_TREADY),
    .crop_Y1_TDATA   (crop_Y1_TDATA),
    .crop_Y1_TVALID  (crop_Y1_TVALID),
    .crop_Y1_TREADY  (crop_Y1_TREADY),
    .crop_X1_TDATA   (crop_X1_TDATA),
    .crop_X1_TVALID  (crop_X1_TVALID),
    .crop_X1_TREADY  (crop_X1_TREADY),
    .pixel_out_TDATA (pixel_out_TDATA),
    .pixel_out_TVALID(pixel_out_TVALID),
    .pixel_out_TREADY(pixel_out_TREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y1;
    int x1;
    bit in_rand;
    int out_mode;
    int first;
    int last;
    int stall;
  } vec_t;

  vec_t vecs[9];

  int checks = 0;
  int failures = 0;
  int out_mode = 0;
  bit hold_pend = 1'b0;
  logic [PW-1:0] hold_data;
  logic [PW-1:0] got[$];
  logic [PW-1:0] exp_q[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: advance to the falling edge, check output stability,
  // drive the sink ready and record any output beat.
  task automatic tick();
    @(negedge clk);
    if (hold_pend) begin
      chk("hold_valid", pixel_out_TVALID, 1);
      chk("hold_data", pixel_out_TDATA, hold_data);
    end
    case (out_mode)
      0: pixel_out_TREADY = 1'b1;
      1: pixel_out_TREADY = ($urandom_range(0, 2) != 0);
      default: pixel_out_TREADY = 1'b0;
    endcase
    hold_pend = pixel_out_TVALID && !pixel_out_TREADY;
    hold_data = pixel_out_TDATA;
    if (pixel_out_TVALID && pixel_out_TREADY)
      got.push_back(pixel_out_TDATA);
  endtask

  task automatic send_params(int y1, int x1);
    tick();
    chk("in_ready_idle", pixel_in_TREADY, 0);
    chk("y1_ready_idle", crop_Y1_TREADY, 1);
    chk("x1_ready_idle", crop_X1_TREADY, 1);
    crop_Y1_TDATA  = RBW'(y1);
    crop_X1_TDATA  = RBW'(x1);
    crop_Y1_TVALID = 1'b1;
    crop_X1_TVALID = 1'b1;
    tick();
    crop_Y1_TVALID = 1'b0;
    crop_X1_TVALID = 1'b0;
    chk("y1_held", crop_Y1_TREADY, 0);
    chk("x1_held", crop_X1_TREADY, 0);
  endtask

  task automatic feed(int base, int n, bit in_rand, output int stall_at);
    int i;
    int guard;
    bit v;
    i = 0;
    guard = 0;
    stall_at = -1;
    while (i < n && guard < 4000) begin
      tick();
      guard++;
      v = in_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      pixel_in_TVALID = v;
      pixel_in_TDATA  = PW'(base + i);
      if (v && !pixel_in_TREADY && stall_at < 0) begin
        stall_at = i;
        if (out_mode == 2) out_mode = 0;
      end
      if (v && pixel_in_TREADY) i++;
    end
    chk("feed_done", i, n);
    tick();
    pixel_in_TVALID = 1'b0;
  endtask

  task automatic run_frame(int y1, int x1, int base, bit in_rand,
                           int mode, int first, int last, int stall);
    int yc;
    int xc;
    int stall_at;
    int guard;
    int n;
    yc = (y1 > IR - OR) ? IR - OR : y1;
    xc = (x1 > IC - OC) ? IC - OC : x1;
    exp_q.delete();
    for (int r = 0; r < IR; r++)
      for (int c = 0; c < IC; c++)
        if (r >= yc && r < yc + OR && c >= xc && c < xc + OC)
          exp_q.push_back(PW'(base + r * IC + c));
    got.delete();
    out_mode = 0;
    send_params(y1, x1);
    out_mode = mode;
    feed(base, FRAME, in_rand, stall_at);
    if (stall >= 0) chk("stall_index", stall_at, stall);
    if (out_mode == 2) out_mode = 0;
    guard = 0;
    while (got.size() < OUT_N && guard < 2000) begin
      tick();
      guard++;
    end
    n = got.size();
    chk("beats", n, OUT_N);
    for (int k = 0; k < n && k < OUT_N; k++)
      chk("pixel", got[k], exp_q[k]);
    if (n > 0) begin
      chk("first", got[0], base + first);
      chk("last", got[n-1], base + last);
    end
    tick();
    chk("empty_after", pixel_out_TVALID, 0);
    chk("y1_ready_again", crop_Y1_TREADY, 1);
    chk("x1_ready_again", crop_X1_TREADY, 1);
  endtask

  initial begin
    int dummy;
    vecs[0] = '{0,  0,  1'b0, 0, 0,   85,  -1};
    vecs[1] = '{7,  14, 1'b0, 0, 154, 239, -1};
    vecs[2] = '{3,  5,  1'b0, 2, 65,  150, 87};
    vecs[3] = '{9,  30, 1'b0, 0, 154, 239, -1};
    vecs[4] = '{2,  14, 1'b1, 1, 54,  139, -1};
    vecs[5] = '{7,  0,  1'b1, 1, 140, 225, -1};
    vecs[6] = '{1,  1,  1'b1, 1, 21,  106, -1};
    vecs[7] = '{0,  14, 1'b1, 1, 14,  99,  -1};
    vecs[8] = '{5,  3,  1'b1, 1, 103, 188, -1};

    reset            = 1'b0;
    pixel_in_TDATA   = '0;
    pixel_in_TVALID  = 1'b0;
    crop_Y1_TDATA    = '0;
    crop_Y1_TVALID   = 1'b0;
    crop_X1_TDATA    = '0;
    crop_X1_TVALID   = 1'b0;
    pixel_out_TREADY = 1'b0;
    out_mode         = 2;
    tick();
    tick();
    chk("rst_in_ready", pixel_in_TREADY, 0);
    chk("rst_out_valid", pixel_out_TVALID, 0);
    chk("rst_y1_ready", crop_Y1_TREADY, 1);
    chk("rst_x1_ready", crop_X1_TREADY, 1);
    reset = 1'b1;

    for (int v = 0; v < 9; v++)
      run_frame(vecs[v].y1, vecs[v].x1, v * 256, vecs[v].in_rand,
                vecs[v].out_mode, vecs[v].first, vecs[v].last,
                vecs[v].stall);

    // Reset in the middle of a frame with pixels buffered.
    got.delete();
    out_mode = 0;
    send_params(0, 0);
    out_mode = 2;
    feed(4000, 10, 1'b0, dummy);
    tick();
    chk("pre_rst_valid", pixel_out_TVALID, 1);
    hold_pend = 1'b0;
    reset = 1'b0;
    tick();
    hold_pend = 1'b0;
    chk("mid_rst_valid", pixel_out_TVALID, 0);
    chk("mid_rst_in_ready", pixel_in_TREADY, 0);
    chk("mid_rst_y1_ready", crop_Y1_TREADY, 1);
    chk("mid_rst_x1_ready", crop_X1_TREADY, 1);
    reset = 1'b1;
    run_frame(3, 5, 5000, 1'b0, 0, 65, 150, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
